direct_sound_fifo: RTL and testbench

Per-channel sample FIFO for Direct Sound A/B. It accepts 32-bit or halfword writes from the bus/DMA path (FIFO_A/FIFO_B register writes) and holds up to 8 words of packed 8-bit PCM samples. It presents the head word show-ahead, together with an occupancy count, to the downstream direct_sound channel, which pops on its read strobe. One instance per channel.

---
 rtl/sound_pkg.sv | 28 ++
 rtl/direct_sound_fifo_if.sv | 41 ++++
 rtl/ds_fifo_mem.sv | 29 ++
 rtl/direct_sound_fifo.sv | 115 +++++++++++
 tb/tb_direct_sound_fifo.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sound_pkg.sv
// -----------------------------------------------------------------------------
// sound_pkg
// Constants shared by the Direct Sound FIFO and the direct_sound channel:
//   DS_FIFO_DEPTH / DS_FIFO_WIDTH - FIFO geometry (8 x 32-bit words)
//   DS_SIZE_W                     - width of the occupancy count (0..DEPTH)
//   HALF_LO / HALF_HI / HALF_WORD - encodings of the wr_half byte-lane strobes
// merge_hi() builds the word pushed by a high-halfword write.
// -----------------------------------------------------------------------------
package sound_pkg;

    localparam int DS_FIFO_DEPTH = 8;
    localparam int DS_FIFO_WIDTH = 32;
    localparam int DS_SIZE_W     = $clog2(DS_FIFO_DEPTH) + 1;

    localparam logic [1:0] HALF_NONE = 2'b00;
    localparam logic [1:0] HALF_LO   = 2'b01;
    localparam logic [1:0] HALF_HI   = 2'b10;
    localparam logic [1:0] HALF_WORD = 2'b11;

    // A high-half write completes a word; the low half comes from the held
    // halfword if one is pending, otherwise it is zero.
    function automatic logic [31:0] merge_hi(input logic [15:0] hi,
                                             input logic [15:0] lo,
                                             input logic        lo_valid);
        return {hi, (lo_valid ? lo : 16'h0000)};
    endfunction

endpackage

// File: rtl/direct_sound_fifo_if.sv
// -----------------------------------------------------------------------------
// direct_sound_fifo_if
// Bundle between the bus/DMA writer + direct_sound reader and the FIFO.
//   master: drives wr_en, wr_half, wr_data, FIFO_re, FIFO_clr
//   slave : the FIFO; drives FIFO_value, FIFO_size, full, empty,
//           overflow, underflow
// Handshake: there is no backpressure. A write is taken on every clock edge
// where wr_en = 1 and is dropped (overflow set) if there is no room; a pop is
// taken on every edge where FIFO_re = 1 and is ignored (underflow set) when
// empty. FIFO_clr overrides both in the same cycle.
// -----------------------------------------------------------------------------
interface direct_sound_fifo_if
    import sound_pkg::*;
#(
    parameter int DEPTH = DS_FIFO_DEPTH,
    parameter int WIDTH = DS_FIFO_WIDTH
) ();
    localparam int SIZE_W = $clog2(DEPTH) + 1;

    logic                wr_en;
    logic [1:0]          wr_half;
    logic [WIDTH-1:0]    wr_data;
    logic                FIFO_re;
    logic                FIFO_clr;
    logic [WIDTH-1:0]    FIFO_value;
    logic [SIZE_W-1:0]   FIFO_size;
    logic                full;
    logic                empty;
    logic                overflow;
    logic                underflow;

    modport master (
        output wr_en, wr_half, wr_data, FIFO_re, FIFO_clr,
        input  FIFO_value, FIFO_size, full, empty, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_half, wr_data, FIFO_re, FIFO_clr,
        output FIFO_value, FIFO_size, full, empty, overflow, underflow
    );
endinterface

// File: rtl/ds_fifo_mem.sv
// -----------------------------------------------------------------------------
// ds_fifo_mem
// DEPTH x WIDTH register array, synchronous write, asynchronous read.
// Contents are deliberately not reset; validity is tracked by the owner.
//   clock - write clock
//   we, waddr, wdata - write port
//   raddr -> rdata   - combinational read port
// -----------------------------------------------------------------------------
module ds_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];
endmodule

// File: rtl/direct_sound_fifo.sv
// -----------------------------------------------------------------------------
// direct_sound_fifo
// Per-channel sample FIFO for Direct Sound A/B. Accepts word or halfword
// writes, stores up to DEPTH words, presents the head word show-ahead.
//   clock, reset - system clock, asynchronous active-high reset
//   bus (slave)  - writes, pop strobe, clear; head value, size and flags out
// All outputs come from registered state only.
// -----------------------------------------------------------------------------
module direct_sound_fifo
    import sound_pkg::*;
#(
    parameter int DEPTH = DS_FIFO_DEPTH,
    parameter int WIDTH = DS_FIFO_WIDTH
) (
    input  logic                clock,
    input  logic                reset,
    direct_sound_fifo_if.slave  bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int SIZE_W = $clog2(DEPTH) + 1;
    localparam logic [SIZE_W-1:0] FULL_COUNT = SIZE_W'(DEPTH);

    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [SIZE_W-1:0] r_count;
    logic [15:0]       r_hold_lo;
    logic              r_hold_valid;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_empty;
    logic              w_full;
    logic              w_push_req;
    logic              w_push_ok;
    logic              w_pop_ok;
    logic              w_mem_we;
    logic [WIDTH-1:0]  w_push_word;
    logic [WIDTH-1:0]  w_mem_rdata;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_COUNT);

    // Only full-word and high-half writes produce a word; a low-half write
    // just parks its data until the matching high half arrives.
    assign w_push_req  = bus.wr_en && ((bus.wr_half == HALF_WORD) || (bus.wr_half == HALF_HI));
    assign w_push_word = (bus.wr_half == HALF_WORD) ? bus.wr_data
                       : merge_hi(bus.wr_data[31:16], r_hold_lo, r_hold_valid);

    assign w_pop_ok  = bus.FIFO_re && !w_empty;
    // When full, a same-cycle pop frees the slot being written.
    assign w_push_ok = w_push_req && (!w_full || w_pop_ok);
    assign w_mem_we  = w_push_ok && !bus.FIFO_clr;

    ds_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clock (clock),
        .we    (w_mem_we),
        .waddr (r_wr_ptr),
        .wdata (w_push_word),
        .raddr (r_rd_ptr),
        .rdata (w_mem_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_hold_lo    <= '0;
            r_hold_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else if (bus.FIFO_clr) begin
            // Clear wins over everything in the same cycle; array is left as is.
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_hold_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            if (bus.wr_en && (bus.wr_half == HALF_LO)) begin
                r_hold_lo    <= bus.wr_data[15:0];
                r_hold_valid <= 1'b1;
            end else if (bus.wr_en && (bus.wr_half == HALF_HI)) begin
                // Consumed even if the merged word is dropped for lack of room.
                r_hold_valid <= 1'b0;
            end

            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + SIZE_W'(w_push_ok) - SIZE_W'(w_pop_ok);

            if (w_push_req && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            if (bus.FIFO_re && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.FIFO_value = w_empty ? '0 : w_mem_rdata;
    assign bus.FIFO_size  = r_count;
    assign bus.full       = w_full;
    assign bus.empty      = w_empty;
    assign bus.overflow   = r_overflow;
    assign bus.underflow  = r_underflow;
endmodule

// File: tb/tb_direct_sound_fifo.sv
// -----------------------------------------------------------------------------
// tb_direct_sound_fifo
// Self-checking bench for direct_sound_fifo: a table of directed vectors,
// hand-written corner sequences, and random traffic compared against a
// queue-based reference model.
// -----------------------------------------------------------------------------
module tb_direct_sound_fifo;
    import sound_pkg::*;

    localparam int DEPTH = 8;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    direct_sound_fifo_if #(.DEPTH(DEPTH), .WIDTH(32)) bus ();

    direct_sound_fifo #(.DEPTH(DEPTH), .WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / reference model ----------------
    logic [31:0] exp_q[$];
    logic [15:0] m_hold_lo;
    bit          m_hold_valid;
    bit          m_ovf;
    bit          m_udf;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_hold_valid = 1'b0;
        m_hold_lo    = 16'h0;
        m_ovf        = 1'b0;
        m_udf        = 1'b0;
    endtask

    task automatic model_step(input bit we, input logic [1:0] half, input logic [31:0] data,
                              input bit re, input bit clr);
        bit          has_push;
        bit          pop_ok;
        logic [31:0] word;
        if (clr) begin
            exp_q.delete();
            m_hold_valid = 1'b0;
            m_ovf        = 1'b0;
            m_udf        = 1'b0;
            return;
        end
        has_push = 1'b0;
        word     = 32'h0;
        if (we) begin
            if (half == 2'b11) begin
                has_push = 1'b1;
                word     = data;
            end else if (half == 2'b01) begin
                m_hold_lo    = data[15:0];
                m_hold_valid = 1'b1;
            end else if (half == 2'b10) begin
                has_push     = 1'b1;
                word         = {data[31:16], (m_hold_valid ? m_hold_lo : 16'h0000)};
                m_hold_valid = 1'b0;
            end
        end
        pop_ok = re && (exp_q.size() > 0);
        if (re && exp_q.size() == 0) m_udf = 1'b1;
        if (has_push && !(exp_q.size() < DEPTH || pop_ok)) begin
            m_ovf    = 1'b1;
            has_push = 1'b0;
        end
        if (pop_ok) void'(exp_q.pop_front());
        if (has_push) exp_q.push_back(word);
    endtask

    task automatic check_model(input string tag);
        logic [31:0] head;
        head = (exp_q.size() > 0) ? exp_q[0] : 32'h0;
        check($sformatf("%s size", tag),  32'(bus.FIFO_size), 32'(exp_q.size()));
        check($sformatf("%s value", tag), bus.FIFO_value, head);
        check($sformatf("%s ovf", tag),   32'(bus.overflow), 32'(m_ovf));
        check($sformatf("%s udf", tag),   32'(bus.underflow), 32'(m_udf));
        check($sformatf("%s full", tag),  32'(bus.full), 32'(exp_q.size() == DEPTH));
        check($sformatf("%s empty", tag), 32'(bus.empty), 32'(exp_q.size() == 0));
    endtask

    task automatic check_reset_values(input string tag);
        check($sformatf("%s value", tag), bus.FIFO_value, 32'h0);
        check($sformatf("%s size", tag),  32'(bus.FIFO_size), 32'd0);
        check($sformatf("%s full", tag),  32'(bus.full), 32'd0);
        check($sformatf("%s empty", tag), 32'(bus.empty), 32'd1);
        check($sformatf("%s ovf", tag),   32'(bus.overflow), 32'd0);
        check($sformatf("%s udf", tag),   32'(bus.underflow), 32'd0);
    endtask

    // ---------------- driver ----------------
    // Inputs change 1 time unit after the rising edge and are held for one
    // full cycle; outputs are sampled at the same point.
    task automatic cycle(input bit we, input logic [1:0] half, input logic [31:0] data,
                         input bit re, input bit clr);
        bus.wr_en    = we;
        bus.wr_half  = half;
        bus.wr_data  = data;
        bus.FIFO_re  = re;
        bus.FIFO_clr = clr;
        model_step(we, half, data, re, clr);
        @(posedge clock);
        #1;
        bus.wr_en    = 1'b0;
        bus.wr_half  = 2'b00;
        bus.wr_data  = 32'h0;
        bus.FIFO_re  = 1'b0;
        bus.FIFO_clr = 1'b0;
    endtask

    task automatic push(input logic [31:0] w);
        cycle(1'b1, HALF_WORD, w, 1'b0, 1'b0);
    endtask

    task automatic pop();
        cycle(1'b0, 2'b00, 32'h0, 1'b1, 1'b0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          we;
        logic [1:0]  half;
        logic [31:0] data;
        bit          re;
        bit          clr;
        int          exp_size;
        logic [31:0] exp_value;
        bit          exp_ovf;
        bit          exp_udf;
    } vec_t;

    vec_t vecs[16];

    initial begin
        bus.wr_en    = 1'b0;
        bus.wr_half  = 2'b00;
        bus.wr_data  = 32'h0;
        bus.FIFO_re  = 1'b0;
        bus.FIFO_clr = 1'b0;
        model_reset();

        vecs[0]  = '{1, 2'b11, 32'h11223344, 0, 0, 1, 32'h11223344, 0, 0};
        vecs[1]  = '{1, 2'b11, 32'h55667788, 0, 0, 2, 32'h11223344, 0, 0};
        vecs[2]  = '{1, 2'b11, 32'h99AABBCC, 0, 0, 3, 32'h11223344, 0, 0};
        vecs[3]  = '{1, 2'b11, 32'hDDEEFF00, 0, 0, 4, 32'h11223344, 0, 0};
        vecs[4]  = '{0, 2'b00, 32'h00000000, 1, 0, 3, 32'h55667788, 0, 0};
        vecs[5]  = '{0, 2'b00, 32'h00000000, 1, 0, 2, 32'h99AABBCC, 0, 0};
        vecs[6]  = '{0, 2'b00, 32'h00000000, 1, 0, 1, 32'hDDEEFF00, 0, 0};
        vecs[7]  = '{0, 2'b00, 32'h00000000, 1, 0, 0, 32'h00000000, 0, 0};
        vecs[8]  = '{1, 2'b01, 32'h0000BEEF, 0, 0, 0, 32'h00000000, 0, 0};
        vecs[9]  = '{1, 2'b10, 32'hCAFE0000, 0, 0, 1, 32'hCAFEBEEF, 0, 0};
        vecs[10] = '{0, 2'b00, 32'h00000000, 1, 0, 0, 32'h00000000, 0, 0};
        vecs[11] = '{1, 2'b10, 32'h12340000, 0, 0, 1, 32'h12340000, 0, 0};
        vecs[12] = '{0, 2'b00, 32'h00000000, 1, 0, 0, 32'h00000000, 0, 0};
        vecs[13] = '{0, 2'b00, 32'h00000000, 1, 0, 0, 32'h00000000, 0, 1};
        vecs[14] = '{1, 2'b11, 32'h01020304, 1, 0, 1, 32'h01020304, 0, 1};
        vecs[15] = '{1, 2'b11, 32'h0BADF00D, 1, 1, 0, 32'h00000000, 0, 0};

        // reset
        repeat (2) @(posedge clock);
        #1;
        check_reset_values("reset");
        reset = 1'b0;

        // table
        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].we, vecs[i].half, vecs[i].data, vecs[i].re, vecs[i].clr);
            check($sformatf("vec%0d size", i),  32'(bus.FIFO_size), 32'(vecs[i].exp_size));
            check($sformatf("vec%0d value", i), bus.FIFO_value, vecs[i].exp_value);
            check($sformatf("vec%0d ovf", i),   32'(bus.overflow), 32'(vecs[i].exp_ovf));
            check($sformatf("vec%0d udf", i),   32'(bus.underflow), 32'(vecs[i].exp_udf));
            check($sformatf("vec%0d empty", i), 32'(bus.empty), 32'(vecs[i].exp_size == 0));
        end

        // overflow at full, then write+pop at full
        for (int i = 0; i < DEPTH; i++) push(32'hA000_0000 + 32'(i));
        check("fill full", 32'(bus.full), 32'd1);
        check("fill size", 32'(bus.FIFO_size), 32'd8);
        push(32'hDEADBEEF);
        check("ovf flag", 32'(bus.overflow), 32'd1);
        check("ovf size", 32'(bus.FIFO_size), 32'd8);
        check("ovf head", bus.FIFO_value, 32'hA000_0000);
        cycle(1'b1, HALF_WORD, 32'hF00DF00D, 1'b1, 1'b0);
        check("full rw size", 32'(bus.FIFO_size), 32'd8);
        check("full rw head", bus.FIFO_value, 32'hA000_0001);
        for (int i = 0; i < 7; i++) pop();
        check("full rw tail", bus.FIFO_value, 32'hF00DF00D);
        check("full rw tail size", 32'(bus.FIFO_size), 32'd1);
        cycle(1'b0, 2'b00, 32'h0, 1'b0, 1'b1);
        check_model("after clr1");

        // clear with pending half and simultaneous push
        pop();
        check("udf set", 32'(bus.underflow), 32'd1);
        for (int i = 0; i < 5; i++) push(32'hB000_0000 + 32'(i));
        cycle(1'b1, HALF_LO, 32'h0000_1111, 1'b0, 1'b0);
        check("pre clr size", 32'(bus.FIFO_size), 32'd5);
        cycle(1'b1, HALF_WORD, 32'h7777_7777, 1'b0, 1'b1);
        check("clr size", 32'(bus.FIFO_size), 32'd0);
        check("clr empty", 32'(bus.empty), 32'd1);
        check("clr udf", 32'(bus.underflow), 32'd0);
        check("clr ovf", 32'(bus.overflow), 32'd0);
        check("clr value", bus.FIFO_value, 32'h0);
        cycle(1'b1, HALF_HI, 32'hABCD_0000, 1'b0, 1'b0);
        check("post clr hi", bus.FIFO_value, 32'hABCD_0000);
        check("post clr size", 32'(bus.FIFO_size), 32'd1);
        pop();

        // 20 simultaneous push/pop pairs through pointer wrap
        for (int i = 0; i < 3; i++) push($urandom);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, HALF_WORD, $urandom, 1'b1, 1'b0);
            check_model($sformatf("wrap%0d", i));
        end

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            bit heavy;
            bit we;
            bit re;
            bit clr;
            heavy = ((i / 100) % 2) == 0;
            we  = $urandom_range(0, 99) < (heavy ? 80 : 30);
            re  = $urandom_range(0, 99) < (heavy ? 25 : 70);
            clr = $urandom_range(0, 199) == 0;
            cycle(we, 2'($urandom_range(0, 3)), $urandom, re, clr);
            check_model($sformatf("rnd%0d", i));
            check($sformatf("rnd%0d bound", i), 32'(bus.FIFO_size <= 4'(DEPTH)), 32'd1);
        end

        // asynchronous reset mid-stream, with a pending low half
        for (int i = 0; i < 3; i++) push(32'hC000_0000 + 32'(i));
        cycle(1'b1, HALF_LO, 32'h0000_2222, 1'b0, 1'b0);
        pop();
        pop();
        pop();
        pop();
        check("pre rst udf", 32'(bus.underflow), 32'd1);
        push(32'hC0DE_C0DE);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("midrst");
        model_reset();
        #1;
        reset = 1'b0;
        cycle(1'b1, HALF_HI, 32'h5555_0000, 1'b0, 1'b0);
        check("post rst hi", bus.FIFO_value, 32'h5555_0000);
        check_model("post rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
